// File: rtl/mau_action_fetch_pkg.sv
// -----------------------------------------------------------------------------
// mau_action_fetch_pkg
// Shared types and constants for the MAU action-fetch stage.
//   MAU_ACT_DATA_W   : default width of one action-parameter word
//   MAU_ACT_NULL_PTR : resolved pointer value meaning "no parameters"
//   af_meta_t        : per-lookup metadata carried alongside the SRAM read
//   af_state_e       : stage state (RUN accepts work, DRAIN discards returns)
// -----------------------------------------------------------------------------
package mau_action_fetch_pkg;

  localparam int          MAU_ACT_DATA_W   = 128;
  localparam logic [15:0] MAU_ACT_NULL_PTR = 16'hFFFF;

  typedef struct packed {
    logic        hit;
    logic [10:0] hit_idx;
    logic [15:0] action_id;
    logic        null_ptr;
  } af_meta_t;

  typedef enum logic [0:0] {
    AF_RUN   = 1'b0,
    AF_DRAIN = 1'b1
  } af_state_e;

  function automatic logic is_null_ptr(input logic [15:0] ptr);
    return ptr == MAU_ACT_NULL_PTR;
  endfunction

endpackage

// File: rtl/mau_action_fetch_fifo.sv
// -----------------------------------------------------------------------------
// mau_af_fifo
// Synchronous FIFO with a synchronous clear and an occupancy count.
//   clk, rst_n      : clock, asynchronous active-low reset
//   clr             : drop all entries (wins over push/pop in the same cycle)
//   push, push_data : write one entry; accepted when not full or when a pop
//                     happens in the same cycle
//   pop, pop_data   : pop_data is the head entry, removed on pop when not empty
//   empty, full     : occupancy flags
//   count           : number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module mau_af_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  // Push at full count is fine when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed once counted.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mau_action_fetch.sv
// -----------------------------------------------------------------------------
// mau_action_fetch
// Sits behind mau_tcam. Resolves misses to the configured default action,
// reads action parameters from the fixed-latency action SRAM and hands
// {action_id, params} to the action engine in lookup order.
//
// Ports
//   clk, rst_n                 : core clock, asynchronous active-low reset
//   in_valid/in_ready          : lookup input handshake
//   in_hit, in_hit_idx         : TCAM hit flag and matching entry index
//   in_action_id/in_action_ptr : action id and parameter pointer on a hit
//   cfg_def_action_id/_ptr     : quasi-static default action used on a miss
//   flush                      : one-cycle pulse, discard buffered/in-flight work
//   sram_rd_en/_addr/_data     : action SRAM read port, data SRAM_LAT cycles later
//   out_valid/out_ready        : result output handshake
//   out_hit, out_hit_idx       : passed-through lookup metadata
//   out_action_id              : resolved action id
//   out_action_data            : parameter word (zero for the null pointer)
//   out_err                    : parity error on this result
//   stat_hit_cnt/stat_miss_cnt : saturating counts of accepted hits / misses
//   stat_par_err_cnt           : saturating parity-error count (parity build)
//   dbg_state                  : current stage state
//
// Handshake: a transfer happens in every cycle where valid and ready are both
// high. in_ready never depends on in_valid; out_valid never depends on
// out_ready, and an offered result stays at the head until it is taken.
//
// Build option: define MAU_AF_PARITY_EN to widen sram_rd_data by one even
// parity bit (MSB), flag mismatches on out_err and add stat_par_err_cnt.
// -----------------------------------------------------------------------------
module mau_action_fetch
  import mau_action_fetch_pkg::*;
#(
  parameter int ACT_DATA_W = MAU_ACT_DATA_W,
  parameter int ACT_ADDR_W = 10,
  parameter int SRAM_LAT   = 2,
  parameter int OUT_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_hit,
  input  logic [10:0]           in_hit_idx,
  input  logic [15:0]           in_action_id,
  input  logic [15:0]           in_action_ptr,
  input  logic [15:0]           cfg_def_action_id,
  input  logic [15:0]           cfg_def_action_ptr,
  input  logic                  flush,
  output logic                  sram_rd_en,
  output logic [ACT_ADDR_W-1:0] sram_rd_addr,
`ifdef MAU_AF_PARITY_EN
  input  logic [ACT_DATA_W:0]   sram_rd_data,
`else
  input  logic [ACT_DATA_W-1:0] sram_rd_data,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_hit,
  output logic [10:0]           out_hit_idx,
  output logic [15:0]           out_action_id,
  output logic [ACT_DATA_W-1:0] out_action_data,
  output logic                  out_err,
  output logic [31:0]           stat_hit_cnt,
  output logic [31:0]           stat_miss_cnt,
`ifdef MAU_AF_PARITY_EN
  output logic [15:0]           stat_par_err_cnt,
`endif
  output af_state_e             dbg_state
);

  localparam int CW = $clog2(OUT_DEPTH) + 1;
  // FIFO entry: {hit, hit_idx, action_id, data, err}
  localparam int FW = 1 + 11 + 16 + ACT_DATA_W + 1;

  af_state_e state;
  logic      alive;   // low while in reset, high from the first clock after

  // Metadata pipe: stage 0 is the newest; stage SRAM_LAT-1 lines up with
  // sram_rd_data for the same lookup.
  logic [SRAM_LAT-1:0] pipe_vld;
  af_meta_t            pipe_meta [SRAM_LAT];
  af_meta_t            tail_meta;
  logic                tail_vld;

  logic [2:0]          inflight;
  logic [CW-1:0]       fifo_count;
  logic [7:0]          credit_used;
  logic                accept;
  logic [15:0]         res_id;
  logic [15:0]         res_ptr;
  logic                res_null;

  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_clr;
  logic                fifo_empty;
  logic                fifo_full;
  logic [FW-1:0]       fifo_din;
  logic [FW-1:0]       fifo_dout;
  logic [ACT_DATA_W-1:0] push_data_word;
  logic                par_err;

  logic                  h_hit;
  logic [10:0]           h_idx;
  logic [15:0]           h_id;
  logic [ACT_DATA_W-1:0] h_data;
  logic                  h_err;

  // ---------------------------------------------------------------- input side
  always_comb begin
    inflight = '0;
    for (int i = 0; i < SRAM_LAT; i++) inflight = inflight + 3'(pipe_vld[i]);
  end

  assign credit_used = 8'(inflight) + 8'(fifo_count);

  // Reads are only issued when their eventual FIFO slot is already reserved,
  // so returning data can always be written. flush blocks a same-cycle accept.
  assign in_ready = alive && (state == AF_RUN) && !flush &&
                    (credit_used < 8'(OUT_DEPTH));
  assign accept   = in_valid && in_ready;

  assign res_id   = in_hit ? in_action_id  : cfg_def_action_id;
  assign res_ptr  = in_hit ? in_action_ptr : cfg_def_action_ptr;
  assign res_null = is_null_ptr(res_ptr);

  // Null-pointer lookups still take a pipe slot to keep ordering, but skip SRAM.
  assign sram_rd_en   = accept && !res_null;
  assign sram_rd_addr = sram_rd_en ? res_ptr[ACT_ADDR_W-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < SRAM_LAT; i++) pipe_meta[i] <= '0;
    end else begin
      pipe_vld[0]  <= accept;
      pipe_meta[0] <= '{hit: in_hit, hit_idx: in_hit_idx,
                        action_id: res_id, null_ptr: res_null};
      for (int i = 1; i < SRAM_LAT; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_meta[i] <= pipe_meta[i-1];
      end
    end
  end

  assign tail_vld  = pipe_vld[SRAM_LAT-1];
  assign tail_meta = pipe_meta[SRAM_LAT-1];

  // ------------------------------------------------------------ return side
`ifdef MAU_AF_PARITY_EN
  // Even parity: data plus parity bit must reduce to 0.
  assign par_err = !tail_meta.null_ptr && (^sram_rd_data);
`else
  assign par_err = 1'b0;
`endif

  assign push_data_word = tail_meta.null_ptr ? '0 : sram_rd_data[ACT_DATA_W-1:0];
  // Returns that land while draining (or on the flush cycle) are dropped.
  assign fifo_push = tail_vld && (state == AF_RUN) && !flush;
  assign fifo_clr  = flush && (state == AF_RUN);
  assign fifo_pop  = out_valid && out_ready;
  assign fifo_din  = {tail_meta.hit, tail_meta.hit_idx, tail_meta.action_id,
                      push_data_word, par_err};

  mau_af_fifo #(
    .WIDTH (FW),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (fifo_clr),
    .push      (fifo_push),
    .push_data (fifo_din),
    .pop       (fifo_pop),
    .pop_data  (fifo_dout),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign {h_hit, h_idx, h_id, h_data, h_err} = fifo_dout;

  // Result fields read as zero whenever nothing is offered.
  assign out_hit         = out_valid & h_hit;
  assign out_hit_idx     = out_valid ? h_idx  : '0;
  assign out_action_id   = out_valid ? h_id   : '0;
  assign out_action_data = out_valid ? h_data : '0;
  assign out_err         = out_valid & h_err;

  // ------------------------------------------------------------ state machine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= AF_RUN;
      alive <= 1'b0;
    end else begin
      alive <= 1'b1;
      case (state)
        AF_RUN:   if (flush) state <= AF_DRAIN;
        // Leave once every outstanding read has come back and been dropped.
        AF_DRAIN: if (inflight == '0) state <= AF_RUN;
        default:  state <= AF_RUN;
      endcase
    end
  end

  assign dbg_state = state;

  // ---------------------------------------------------------------- counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hit_cnt  <= '0;
      stat_miss_cnt <= '0;
    end else if (accept) begin
      if (in_hit && stat_hit_cnt != '1)   stat_hit_cnt  <= stat_hit_cnt + 32'd1;
      if (!in_hit && stat_miss_cnt != '1) stat_miss_cnt <= stat_miss_cnt + 32'd1;
    end
  end

`ifdef MAU_AF_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_par_err_cnt <= '0;
    end else if (fifo_push && par_err && stat_par_err_cnt != '1) begin
      stat_par_err_cnt <= stat_par_err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mau_action_fetch.sv
// -----------------------------------------------------------------------------
// tb_mau_action_fetch
// Directed bench for mau_action_fetch: SRAM model with SRAM_LAT read latency,
// lookup driver tasks, an in-order scoreboard fed from a small resolution
// model, and a final report. Define MAU_AF_PARITY_EN to cover the parity build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mau_action_fetch;
  import mau_action_fetch_pkg::*;

  localparam int DW    = 128;
  localparam int AW    = 10;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
`ifdef MAU_AF_PARITY_EN
  localparam int SW = DW + 1;
`else
  localparam int SW = DW;
`endif
  localparam int EW = 1 + 11 + 16 + DW + 1;

  // ------------------------------------------------------ clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, in_hit, flush;
  logic [10:0]   in_hit_idx;
  logic [15:0]   in_action_id, in_action_ptr;
  logic [15:0]   cfg_def_action_id, cfg_def_action_ptr;
  logic          sram_rd_en;
  logic [AW-1:0] sram_rd_addr;
  logic [SW-1:0] sram_rd_data;
  logic          out_valid, out_ready, out_hit, out_err;
  logic [10:0]   out_hit_idx;
  logic [15:0]   out_action_id;
  logic [DW-1:0] out_action_data;
  logic [31:0]   stat_hit_cnt, stat_miss_cnt;
`ifdef MAU_AF_PARITY_EN
  logic [15:0]   stat_par_err_cnt;
`endif
  af_state_e     dbg_state;

  mau_action_fetch #(
    .ACT_DATA_W (DW),
    .ACT_ADDR_W (AW),
    .SRAM_LAT   (LAT),
    .OUT_DEPTH  (DEPTH)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_hit             (in_hit),
    .in_hit_idx         (in_hit_idx),
    .in_action_id       (in_action_id),
    .in_action_ptr      (in_action_ptr),
    .cfg_def_action_id  (cfg_def_action_id),
    .cfg_def_action_ptr (cfg_def_action_ptr),
    .flush              (flush),
    .sram_rd_en         (sram_rd_en),
    .sram_rd_addr       (sram_rd_addr),
    .sram_rd_data       (sram_rd_data),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_hit            (out_hit),
    .out_hit_idx        (out_hit_idx),
    .out_action_id      (out_action_id),
    .out_action_data    (out_action_data),
    .out_err            (out_err),
    .stat_hit_cnt       (stat_hit_cnt),
    .stat_miss_cnt      (stat_miss_cnt),
`ifdef MAU_AF_PARITY_EN
    .stat_par_err_cnt   (stat_par_err_cnt),
`endif
    .dbg_state          (dbg_state)
  );

  // ------------------------------------------------------ SRAM model
  logic [SW-1:0] sram_mem [1024];
  logic [SW-1:0] rd_pipe  [LAT];

  always @(posedge clk) begin
    if (sram_rd_en) rd_pipe[0] <= sram_mem[sram_rd_addr];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign sram_rd_data = rd_pipe[LAT-1];

  int rd_strobes = 0;
  always @(negedge clk) if (rst_n && sram_rd_en) rd_strobes++;

  task automatic mem_write(input int a, input logic [DW-1:0] d);
`ifdef MAU_AF_PARITY_EN
    sram_mem[a] = {^d, d};
`else
    sram_mem[a] = d;
`endif
  endtask

  // ------------------------------------------------------ checking
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // ------------------------------------------------------ scoreboard
  logic [EW-1:0] exp_q[$];
  int            exp_hits   = 0;
  int            exp_misses = 0;

  function automatic logic [EW-1:0] model(input logic hit, input logic [10:0] idx,
                                          input logic [15:0] id, input logic [15:0] ptr);
    logic [15:0]   rid;
    logic [15:0]   rptr;
    logic [DW-1:0] d;
    logic          e;
    rid  = hit ? id  : cfg_def_action_id;
    rptr = hit ? ptr : cfg_def_action_ptr;
    d    = '0;
    e    = 1'b0;
    if (rptr != 16'hFFFF) begin
      d = sram_mem[rptr[AW-1:0]][DW-1:0];
`ifdef MAU_AF_PARITY_EN
      e = ^sram_mem[rptr[AW-1:0]];
`endif
    end
    return {hit, idx, rid, d, e};
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("stale_out", 192'(out_valid), 192'(0));
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        check("result", 192'({out_hit, out_hit_idx, out_action_id, out_action_data, out_err}),
              192'(e));
      end
    end
  end

  // ------------------------------------------------------ driver tasks
  logic          last_rd_en;
  logic [AW-1:0] last_rd_addr;

  // Offer one lookup for one cycle; acc reports whether it was taken.
  task automatic present(input logic hit, input logic [10:0] idx, input logic [15:0] id,
                         input logic [15:0] ptr, input bit track, output bit acc);
    in_valid      = 1'b1;
    in_hit        = hit;
    in_hit_idx    = idx;
    in_action_id  = id;
    in_action_ptr = ptr;
    @(negedge clk);
    acc = in_ready;
    if (acc) begin
      last_rd_en   = sram_rd_en;
      last_rd_addr = sram_rd_addr;
      if (track) exp_q.push_back(model(hit, idx, id, ptr));
      if (hit) exp_hits++;
      else     exp_misses++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drive_lookup(input logic hit, input logic [10:0] idx, input logic [15:0] id,
                              input logic [15:0] ptr, input bit track);
    bit acc;
    acc = 1'b0;
    for (int n = 0; n < 40 && !acc; n++) present(hit, idx, id, ptr, track, acc);
    if (!acc) check("accept_timeout", 192'(in_ready), 192'(1));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("drain_timeout", 192'(exp_q.size()), 192'(0));
  endtask

  // ------------------------------------------------------ stimulus
  initial begin
    int base;
    int k;
    int lat;
    bit acc;

    in_valid           = 1'b1;  // must be ignored during reset
    in_hit             = 1'b1;
    in_hit_idx         = 11'h001;
    in_action_id       = 16'h1001;
    in_action_ptr      = 16'h0010;
    cfg_def_action_id  = 16'h00FE;
    cfg_def_action_ptr = 16'h0020;
    flush              = 1'b0;
    out_ready          = 1'b1;
    last_rd_en         = 1'b0;
    last_rd_addr       = '0;
    for (int i = 0; i < 1024; i++) sram_mem[i] = '0;
    for (int i = 0; i < LAT; i++) rd_pipe[i] = '0;
    mem_write(16'h10, {16{8'hA5}});
    mem_write(16'h20, {4{32'hDEAD_BEEF}});
    for (int i = 16'h30; i < 16'h60; i++) mem_write(i, {96'h0, 32'hC0DE_0000 + 32'(i)});

    // Reset behaviour
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",   192'(in_ready),      192'(0));
    check("rst_out_valid",  192'(out_valid),     192'(0));
    check("rst_rd_en",      192'(sram_rd_en),    192'(0));
    check("rst_rd_addr",    192'(sram_rd_addr),  192'(0));
    check("rst_out_id",     192'(out_action_id), 192'(0));
    check("rst_hit_cnt",    192'(stat_hit_cnt),  192'(0));
    check("rst_miss_cnt",   192'(stat_miss_cnt), 192'(0));
    check("rst_state",      192'(dbg_state),     192'(AF_RUN));
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_ready", 192'(in_ready), 192'(1));
    @(posedge clk);
    #1;

    // 1: hit, latency SRAM_LAT+1
    drive_lookup(1'b1, 11'h005, 16'h1001, 16'h0010, 1'b1);
    check("t1_rd_en",   192'(last_rd_en),   192'(1));
    check("t1_rd_addr", 192'(last_rd_addr), 192'(10'h010));
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    check("t1_latency", 192'(lat), 192'(3));
    wait_idle();
    check("t1_hit_cnt", 192'(stat_hit_cnt), 192'(1));

    // 2: miss resolves to the default action
    drive_lookup(1'b0, 11'h7FF, 16'hBEEF, 16'h0010, 1'b1);
    check("t2_rd_addr", 192'(last_rd_addr), 192'(10'h020));
    wait_idle();
    check("t2_miss_cnt", 192'(stat_miss_cnt), 192'(1));

    // 3: null pointer between two real reads
    base = rd_strobes;
    drive_lookup(1'b1, 11'h001, 16'h3000, 16'h0030, 1'b1);
    drive_lookup(1'b1, 11'h002, 16'h3001, 16'hFFFF, 1'b1);
    check("t3_null_rd_en", 192'(last_rd_en), 192'(0));
    drive_lookup(1'b1, 11'h003, 16'h3002, 16'h0031, 1'b1);
    wait_idle();
    check("t3_strobes", 192'(rd_strobes - base), 192'(2));

    // 4: backpressure, credit limit of OUT_DEPTH
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 8; c++) begin
      present(1'b1, 11'(16 + k), 16'(16'h2000 + k), 16'(16'h0040 + k), 1'b1, acc);
      if (acc) k++;
    end
    check("t4_accepted", 192'(k), 192'(DEPTH));
    @(negedge clk);
    check("t4_in_ready", 192'(in_ready),  192'(0));
    check("t4_out_valid", 192'(out_valid), 192'(1));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle();

    // 5: flush with 2 results buffered and 2 reads in flight
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      drive_lookup(1'b1, 11'(32 + i), 16'(16'h4000 + i), 16'(16'h0050 + i), 1'b0);
    flush         = 1'b1;
    in_valid      = 1'b1;
    in_hit        = 1'b1;
    in_action_ptr = 16'h0010;
    @(negedge clk);
    check("t5_pre_valid",    192'(out_valid),  192'(1));
    check("t5_flush_ready",  192'(in_ready),   192'(0));
    check("t5_flush_rd_en",  192'(sram_rd_en), 192'(0));
    @(posedge clk);
    #1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("t5_d1_valid", 192'(out_valid), 192'(0));
    check("t5_d1_ready", 192'(in_ready),  192'(0));
    check("t5_d1_state", 192'(dbg_state), 192'(AF_DRAIN));
    @(negedge clk);
    check("t5_d2_valid", 192'(out_valid), 192'(0));
    check("t5_d2_ready", 192'(in_ready),  192'(0));
    @(negedge clk);
    check("t5_run_ready", 192'(in_ready),  192'(1));
    check("t5_run_state", 192'(dbg_state), 192'(AF_RUN));
    check("t5_run_valid", 192'(out_valid), 192'(0));
    @(posedge clk);
    #1;
    drive_lookup(1'b1, 11'h0AA, 16'h5555, 16'h0020, 1'b1);
    wait_idle();

`ifdef MAU_AF_PARITY_EN
    // 6: corrupted parity on one word only
    sram_mem[16'h10][DW] = ~sram_mem[16'h10][DW];
    drive_lookup(1'b1, 11'h010, 16'h6000, 16'h0010, 1'b1);
    drive_lookup(1'b1, 11'h011, 16'h6001, 16'h0020, 1'b1);
    wait_idle();
    check("t6_par_cnt", 192'(stat_par_err_cnt), 192'(1));
`endif

    check("final_hit_cnt",  192'(stat_hit_cnt),  192'(exp_hits));
    check("final_miss_cnt", 192'(stat_miss_cnt), 192'(exp_misses));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (checks %0d)", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
